// File: rtl/si5340_i2c_target.sv
// I2C target modelling the Si5340 register interface: 7-bit address, 8-bit
// register pointer, page register at 0x01, auto-incrementing reads and writes.
module si5340_i2c_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h74,
    parameter int unsigned MEM_AW   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_pad_i,
    input  logic        sda_pad_i,
    output logic        sda_pad_o,
    output logic        sda_padoen_o,
    output logic        wr_stb_o,
    output logic [15:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic [7:0]  page_o,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_REG, S_ACK_R,
        S_WDATA, S_ACK_W, S_RDATA, S_IGNORE
    } state_t;

    // {history, sync2, sync1}
    logic [2:0]  scl_sync_q, scl_sync_d;
    logic [2:0]  sda_sync_q, sda_sync_d;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        rw_q, rw_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  page_q, page_d;
    logic        oen_q, oen_d;
    logic        busy_q, busy_d;
    logic        stb_q, stb_d;
    logic [15:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [7:0]  mem [0:(2**MEM_AW)-1];
    logic        mem_we;
    logic [MEM_AW-1:0] wr_idx, rd_idx;
    logic [7:0]  rd_ptr, rd_data, in_byte;
    logic        scl, sda, scl_rise, scl_fall, start_det, stop_det;

    assign scl       = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl & ~scl_sync_q[2];
    assign scl_fall  = ~scl & scl_sync_q[2];
    assign start_det = scl & scl_sync_q[2] & sda_sync_q[2] & ~sda;
    assign stop_det  = scl & scl_sync_q[2] & ~sda_sync_q[2] & sda;

    assign in_byte = {sr_q[6:0], sda};
    assign wr_idx  = MEM_AW'({page_q, ptr_q});
    // During a read burst the next byte is fetched one pointer ahead
    assign rd_ptr  = (state_q == S_RDATA) ? ptr_q + 8'd1 : ptr_q;
    assign rd_idx  = MEM_AW'({page_q, rd_ptr});
    assign rd_data = mem[rd_idx];

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_pad_i};
        sda_sync_d = {sda_sync_q[1:0], sda_pad_i};
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        page_d     = page_q;
        oen_d      = oen_q;
        busy_d     = busy_q;
        stb_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;

        if (stop_det) begin
            state_d = S_IDLE;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (start_det) begin
            state_d = S_ADDR;
            oen_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_ADDR, S_REG: begin
                    if (scl_rise) begin
                        sr_d  = in_byte;
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == S_REG) begin
                            ptr_d   = sr_q;
                            oen_d   = 1'b0;
                            state_d = S_ACK_R;
                        end else if (sr_q[7:1] == DEV_ADDR) begin
                            rw_d    = sr_q[0];
                            oen_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_ACK_A;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ACK_A: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            sr_d    = rd_data;
                            oen_d   = rd_data[7];
                            state_d = S_RDATA;
                        end else begin
                            oen_d   = 1'b1;
                            state_d = S_REG;
                        end
                    end
                end
                S_ACK_R, S_ACK_W: begin
                    if (scl_fall) begin
                        oen_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        sr_d  = in_byte;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            stb_d   = 1'b1;
                            waddr_d = {page_q, ptr_q};
                            wdata_d = in_byte;
                            mem_we  = 1'b1;
                            if (ptr_q == 8'h01) page_d = in_byte;
                            ptr_d   = ptr_q + 8'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oen_d   = 1'b0;
                        state_d = S_ACK_W;
                    end
                end
                S_RDATA: begin
                    // cnt counts rising edges of the current byte; 8 means ACK slot
                    if (scl_rise) begin
                        if (cnt_q == 4'd8) begin
                            if (!sda) begin
                                ptr_d = ptr_q + 8'd1;
                                sr_d  = rd_data;
                                cnt_d = '0;
                            end else begin
                                oen_d   = 1'b1;
                                state_d = S_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (scl_fall) begin
                        oen_d = (cnt_q == 4'd8) ? 1'b1 : sr_q[~cnt_q[2:0]];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            page_q     <= '0;
            oen_q      <= 1'b1;
            busy_q     <= 1'b0;
            stb_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            page_q     <= page_d;
            oen_q      <= oen_d;
            busy_q     <= busy_d;
            stb_q      <= stb_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem[wr_idx] <= in_byte;
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen_q;
    assign wr_stb_o     = stb_q;
    assign wr_addr_o    = waddr_q;
    assign wr_data_o    = wdata_q;
    assign page_o       = page_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_si5340_i2c_target.sv
// Bench for si5340_i2c_target: bit-banged I2C master, table-driven write
// vectors, hand sequences for read/reset, and randomized traffic vs a model.
module tb_si5340_i2c_target;

    localparam int unsigned Q = 5;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        scl_m, sda_m, sda_line;
    logic        sda_pad_o, sda_padoen_o, wr_stb_o, busy_o;
    logic [15:0] wr_addr_o;
    logic [7:0]  wr_data_o, page_o;

    always #5 clk = ~clk;

    assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

    si5340_i2c_target #(.DEV_ADDR(7'h74), .MEM_AW(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .scl_pad_i(scl_m), .sda_pad_i(sda_line),
        .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .wr_stb_o(wr_stb_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .page_o(page_o), .busy_o(busy_o)
    );

    int unsigned n_cmp = 0, n_err = 0;
    logic        mon_en = 1'b0;
    logic [23:0] stb_q [$];
    int unsigned oen_low = 0, oen_bad = 0, pad_bad = 0;
    logic        oen_prev = 1'b1;

    // Reference model state: memory (indexed by low 8 bits of {page,reg}) and page
    logic [7:0]  mem_m [256];
    bit          mem_v [256];
    logic [7:0]  page_m = 8'h00;

    typedef struct {
        logic [7:0]  addr_byte;
        logic [7:0]  reg_a;
        int unsigned nw;
        logic [7:0]  wd [4];
        int unsigned exp_acks;
        int unsigned exp_stb;
        logic [15:0] exp_addr [4];
        logic [7:0]  exp_page;
    } vec_t;

    vec_t vecs [6];

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_stb_o) stb_q.push_back({wr_addr_o, wr_data_o});
            if (!sda_padoen_o) oen_low++;
            if (sda_padoen_o !== oen_prev && scl_m !== 1'b0) oen_bad++;
            oen_prev = sda_padoen_o;
            if (sda_pad_o !== 1'b0) pad_bad++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b, output logic s);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); s = sda_line;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) write_bit(b[i], s);
        write_bit(1'b1, s);
        ack = (s == 1'b0);
    endtask

    task automatic rbyte(output logic [7:0] d, input bit give_ack);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            write_bit(1'b1, s);
            d = {d[6:0], s};
        end
        write_bit(give_ack ? 1'b0 : 1'b1, s);
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] ra, input int unsigned n,
                            input logic [7:0] d [4], output int unsigned acks);
        logic        a;
        logic [23:0] exp_q [$];
        logic [7:0]  p;
        bit          match;
        match = (ab == 8'hE8);
        stb_q.delete();
        oen_low = 0;
        acks = 0;
        i2c_start();
        wbyte(ab, a); acks += a;
        check("busy_after_addr", busy_o, match);
        wbyte(ra, a); acks += a;
        for (int i = 0; i < int'(n); i++) begin
            wbyte(d[i], a); acks += a;
        end
        i2c_stop();
        wait_clk(4);
        if (match) begin
            p = ra;
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({page_m, p, d[i]});
                mem_m[p] = d[i];
                mem_v[p] = 1'b1;
                if (p == 8'h01) page_m = d[i];
                p = p + 8'd1;
            end
        end
        check("model_acks", acks, match ? n + 2 : 0);
        check("model_stb_count", stb_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
            check("model_stb", stb_q[i], exp_q[i]);
        check("model_page", page_o, page_m);
        check("busy_after_stop", busy_o, 1'b0);
        if (!match) check("sda_never_driven", oen_low, 0);
    endtask

    task automatic do_read(input logic [7:0] ra, input int unsigned n);
        logic       a;
        logic [7:0] p, rd;
        stb_q.delete();
        i2c_start();
        wbyte(8'hE8, a); check("rd_wr_addr_ack", a, 1'b1);
        wbyte(ra, a);    check("rd_reg_ack", a, 1'b1);
        i2c_start();
        wbyte(8'hE9, a); check("rd_addr_ack", a, 1'b1);
        p = ra;
        for (int i = 0; i < int'(n); i++) begin
            rbyte(rd, i != int'(n) - 1);
            if (mem_v[p]) check("rd_data", rd, mem_m[p]);
            p = p + 8'd1;
        end
        wait_clk(2);
        check("rd_released_after_nack", sda_padoen_o, 1'b1);
        i2c_stop();
        wait_clk(4);
        check("rd_no_strobes", stb_q.size(), 0);
        check("rd_busy_after_stop", busy_o, 1'b0);
    endtask

    initial begin
        int unsigned acks;
        logic        a;
        logic [7:0]  rd;
        logic [7:0]  rnd_d [4];
        logic [7:0]  one [4];
        logic [6:0]  bad;
        logic [7:0]  ra;
        int unsigned kind, n;

        vecs[0] = '{addr_byte: 8'hE8, reg_a: 8'h10, nw: 3, wd: '{8'hAA, 8'hBB, 8'hCC, 8'h00},
                    exp_acks: 5, exp_stb: 3, exp_addr: '{16'h0010, 16'h0011, 16'h0012, 16'h0000}, exp_page: 8'h00};
        vecs[1] = '{addr_byte: 8'hE8, reg_a: 8'h01, nw: 1, wd: '{8'h0B, 8'h00, 8'h00, 8'h00},
                    exp_acks: 3, exp_stb: 1, exp_addr: '{16'h0001, 16'h0000, 16'h0000, 16'h0000}, exp_page: 8'h0B};
        vecs[2] = '{addr_byte: 8'hE8, reg_a: 8'hFF, nw: 2, wd: '{8'h11, 8'h22, 8'h00, 8'h00},
                    exp_acks: 4, exp_stb: 2, exp_addr: '{16'h0BFF, 16'h0B00, 16'h0000, 16'h0000}, exp_page: 8'h0B};
        vecs[3] = '{addr_byte: 8'hEA, reg_a: 8'h23, nw: 1, wd: '{8'h77, 8'h00, 8'h00, 8'h00},
                    exp_acks: 0, exp_stb: 0, exp_addr: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, exp_page: 8'h0B};
        vecs[4] = '{addr_byte: 8'hE8, reg_a: 8'h01, nw: 1, wd: '{8'h00, 8'h00, 8'h00, 8'h00},
                    exp_acks: 3, exp_stb: 1, exp_addr: '{16'h0B01, 16'h0000, 16'h0000, 16'h0000}, exp_page: 8'h00};
        vecs[5] = '{addr_byte: 8'hE8, reg_a: 8'h23, nw: 1, wd: '{8'h5A, 8'h00, 8'h00, 8'h00},
                    exp_acks: 3, exp_stb: 1, exp_addr: '{16'h0023, 16'h0000, 16'h0000, 16'h0000}, exp_page: 8'h00};

        rst_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(5);
        check("rst_oen", sda_padoen_o, 1'b1);
        check("rst_pad_o", sda_pad_o, 1'b0);
        check("rst_stb", wr_stb_o, 1'b0);
        check("rst_addr", wr_addr_o, 16'h0000);
        check("rst_data", wr_data_o, 8'h00);
        check("rst_page", page_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        wait_clk(5);
        mon_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_write(vecs[v].addr_byte, vecs[v].reg_a, vecs[v].nw, vecs[v].wd, acks);
            check($sformatf("vec%0d_acks", v), acks, vecs[v].exp_acks);
            check($sformatf("vec%0d_stb_count", v), stb_q.size(), vecs[v].exp_stb);
            for (int i = 0; i < int'(vecs[v].exp_stb) && i < stb_q.size(); i++) begin
                check($sformatf("vec%0d_stb%0d_addr", v, i), stb_q[i][23:8], vecs[v].exp_addr[i]);
                check($sformatf("vec%0d_stb%0d_data", v, i), stb_q[i][7:0], vecs[v].wd[i]);
            end
            check($sformatf("vec%0d_page", v), page_o, vecs[v].exp_page);
        end

        // Read back 0x23 (single byte, NACK), then a two-byte burst from 0x10
        stb_q.delete();
        i2c_start();
        wbyte(8'hE8, a); check("rb_wr_ack", a, 1'b1);
        wbyte(8'h23, a); check("rb_reg_ack", a, 1'b1);
        i2c_start();
        wbyte(8'hE9, a); check("rb_rd_ack", a, 1'b1);
        rbyte(rd, 1'b0);
        check("rb_data_5a", rd, 8'h5A);
        wait_clk(2);
        check("rb_released", sda_padoen_o, 1'b1);
        i2c_stop();
        wait_clk(4);
        check("rb_no_strobe", stb_q.size(), 0);
        check("rb_busy_low", busy_o, 1'b0);
        do_read(8'h10, 2);

        // Reset in the middle of a data byte
        one = '{8'h0B, 8'h00, 8'h00, 8'h00};
        do_write(8'hE8, 8'h01, 1, one, acks);
        stb_q.delete();
        i2c_start();
        wbyte(8'hE8, a);
        wbyte(8'h30, a);
        for (int i = 0; i < 4; i++) write_bit(i[0], a);
        rst_i = 1'b1;
        wait_clk(1);
        rst_i = 1'b0;
        check("mid_rst_oen", sda_padoen_o, 1'b1);
        check("mid_rst_page", page_o, 8'h00);
        check("mid_rst_busy", busy_o, 1'b0);
        page_m = 8'h00;
        i2c_stop();
        wait_clk(4);
        check("mid_rst_no_strobe", stb_q.size(), 0);
        one = '{8'hC3, 8'h00, 8'h00, 8'h00};
        do_write(8'hE8, 8'h40, 1, one, acks);
        check("post_rst_strobe", stb_q.size() > 0 ? stb_q[0] : 24'hFFFFFF, 24'h0040C3);

        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) rnd_d[i] = 8'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            if (kind <= 1) begin
                do_write(8'hE8, ra, n, rnd_d, acks);
            end else if (kind == 2) begin
                for (int k = 0; k < 64 && !mem_v[ra]; k++) ra = 8'($urandom);
                do_read(ra, $urandom_range(1, 3));
            end else begin
                bad = 7'($urandom);
                if (bad == 7'h74) bad = 7'h75;
                do_write({bad, 1'b0}, ra, n, rnd_d, acks);
            end
        end

        check("oen_changes_only_scl_low", oen_bad, 0);
        check("sda_pad_o_constant_zero", pad_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
